// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port byte RAM between a video read port and
// a CPU read/write port. Video has fixed priority; each port holds at most
// one access from strobe acceptance until its ack.
// Each access is issued by registering ram_a/ram_d/ram_w. ram_q returns one
// clock later. A 2-entry owner/valid pipeline steers each returning byte to
// vq or cq, and raises the matching one-cycle ack.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   vstb, va            video read strobe and byte address
//   vack, vq            video completion pulse and read data (held)
//   cstb, ca, cd, cw    CPU strobe, address, write data, type (1=write)
//   cack, cq            CPU completion pulse and data (held)
//   ram_a, ram_d, ram_w registered RAM address, write data, write enable
//   ram_q               RAM read data, valid one clock after ram_a
module ram_arbiter #(
  parameter int AW = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vstb,
  input  logic [AW-1:0] va,
  output logic          vack,
  output logic [7:0]    vq,
  input  logic          cstb,
  input  logic [AW-1:0] ca,
  input  logic [7:0]    cd,
  input  logic          cw,
  output logic          cack,
  output logic [7:0]    cq,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_w,
  input  logic [7:0]    ram_q
);

  typedef enum logic {
    OWN_VIDEO = 1'b0,
    OWN_CPU   = 1'b1
  } owner_t;

  // One slot of the return pipeline. A CPU write carries its byte so that
  // cq can echo it at ack time.
  typedef struct packed {
    logic       valid;
    owner_t     owner;
    logic       write;
    logic [7:0] wdata;
  } stage_t;

  stage_t s1;  // issued last edge; RAM is reading this cycle
  stage_t s2;  // ram_q holds this slot's data this cycle

  // Pending registers: accepted but not yet issued.
  logic          v_pend;
  logic [AW-1:0] v_pa;
  logic          c_pend;
  logic [AW-1:0] c_pa;
  logic [7:0]    c_pd;
  logic          c_pw;

  logic          v_busy, c_busy;
  logic          v_take, c_take;
  logic          v_cand, c_cand;
  logic          issue_v, issue_c;
  logic [AW-1:0] v_addr, c_addr;
  logic [7:0]    c_data;
  logic          c_write;

  // A port stays busy while its access is pending or in either pipeline slot.
  // The slot empties at the edge that raises the ack, so a new strobe is
  // accepted in the ack cycle itself.
  // NOTE: every always_comb output is given a default first so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    v_busy  = 1'b0;
    c_busy  = 1'b0;
    v_take  = 1'b0;
    c_take  = 1'b0;
    v_cand  = 1'b0;
    c_cand  = 1'b0;
    issue_v = 1'b0;
    issue_c = 1'b0;
    v_addr  = va;
    c_addr  = ca;
    c_data  = cd;
    c_write = cw;

    v_busy = v_pend
           | (s1.valid & (s1.owner == OWN_VIDEO))
           | (s2.valid & (s2.owner == OWN_VIDEO));
    c_busy = c_pend
           | (s1.valid & (s1.owner == OWN_CPU))
           | (s2.valid & (s2.owner == OWN_CPU));

    v_take = vstb & ~v_busy;
    c_take = cstb & ~c_busy;

    v_cand = v_pend | v_take;
    c_cand = c_pend | c_take;

    // Fixed video priority. The CPU can lose at most once in a row, because
    // video stays busy for several cycles after it wins.
    issue_v = v_cand;
    issue_c = c_cand & ~v_cand;

    if (v_pend) begin
      v_addr = v_pa;
    end
    if (c_pend) begin
      c_addr  = c_pa;
      c_data  = c_pd;
      c_write = c_pw;
    end
  end

  // NOTE: all state is updated with non-blocking assignments. Every register
  // then sees pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_pend <= 1'b0;
      v_pa   <= '0;
      c_pend <= 1'b0;
      c_pa   <= '0;
      c_pd   <= 8'h00;
      c_pw   <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      ram_a  <= '0;
      ram_d  <= 8'h00;
      ram_w  <= 1'b0;
      vack   <= 1'b0;
      vq     <= 8'h00;
      cack   <= 1'b0;
      cq     <= 8'h00;
    end else begin
      // Capture accepted strobes. The pending flag survives only for a
      // candidate that lost arbitration this cycle.
      if (v_take) begin
        v_pa <= va;
      end
      if (c_take) begin
        c_pa <= ca;
        c_pd <= cd;
        c_pw <= cw;
      end
      v_pend <= v_cand & ~issue_v;
      c_pend <= c_cand & ~issue_c;

      // Issue. ram_a/ram_d hold in idle cycles; ram_w is a single-cycle strobe.
      ram_w <= 1'b0;
      s1    <= '0;
      if (issue_v) begin
        ram_a <= v_addr;
        ram_d <= 8'h00;
        s1    <= '{valid: 1'b1, owner: OWN_VIDEO, write: 1'b0, wdata: 8'h00};
      end else if (issue_c) begin
        ram_a <= c_addr;
        ram_d <= c_data;
        ram_w <= c_write;
        s1    <= '{valid: 1'b1, owner: OWN_CPU, write: c_write, wdata: c_data};
      end

      s2 <= s1;

      // Return: ram_q belongs to s2's access during this cycle.
      vack <= s2.valid & (s2.owner == OWN_VIDEO);
      cack <= s2.valid & (s2.owner == OWN_CPU);
      if (s2.valid && s2.owner == OWN_VIDEO) begin
        vq <= ram_q;
      end
      if (s2.valid && s2.owner == OWN_CPU) begin
        cq <= s2.write ? s2.wdata : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter.
// The bench contains a synchronous byte RAM model. Any address that has not
// been written reads back (addr[7:0] ^ 8'h5A).
// A directed table runs first, one row per clock cycle: its inputs and the
// outputs expected in that cycle. Hand-written reset sequences follow. The
// run ends with an alternating video/CPU random run, scored against a
// reference memory and predicted ack cycles.
module tb_ram_arbiter;

  localparam int AW = 17;

  logic          clock = 1'b0;
  logic          reset;
  logic          vstb;
  logic [AW-1:0] va;
  logic          vack;
  logic [7:0]    vq;
  logic          cstb;
  logic [AW-1:0] ca;
  logic [7:0]    cd;
  logic          cw;
  logic          cack;
  logic [7:0]    cq;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_d;
  logic          ram_w;
  logic [7:0]    ram_q;

  ram_arbiter #(.AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .vstb  (vstb),
    .va    (va),
    .vack  (vack),
    .vq    (vq),
    .cstb  (cstb),
    .ca    (ca),
    .cd    (cd),
    .cw    (cw),
    .cack  (cack),
    .cq    (cq),
    .ram_a (ram_a),
    .ram_d (ram_d),
    .ram_w (ram_w),
    .ram_q (ram_q)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: the write lands at the edge; the read data appears one
  // clock after the address.
  logic [7:0] mem [int];
  always @(posedge clock) begin
    if (ram_w) mem[int'(ram_a)] = ram_d;
    ram_q <= mem.exists(int'(ram_a)) ? mem[int'(ram_a)] : (ram_a[7:0] ^ 8'h5A);
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    vstb = 1'b0; va = '0; cstb = 1'b0; ca = '0; cd = 8'h00; cw = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_a"}, 32'(ram_a), 32'h0);
    check({tag, "_ram_d"}, 32'(ram_d), 32'h0);
    check({tag, "_ram_w"}, 32'(ram_w), 32'h0);
    check({tag, "_vack"},  32'(vack),  32'h0);
    check({tag, "_vq"},    32'(vq),    32'h0);
    check({tag, "_cack"},  32'(cack),  32'h0);
    check({tag, "_cq"},    32'(cq),    32'h0);
  endtask

  typedef struct {
    logic          vstb;
    logic [AW-1:0] va;
    logic          cstb;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
    logic          cw;
    logic [AW-1:0] e_a;
    logic          e_w;
    logic [7:0]    e_d;
    logic          e_vack;
    logic [7:0]    e_vq;
    logic          e_cack;
    logic [7:0]    e_cq;
  } vec_t;

  vec_t vecs[$];

  // Random-phase scoreboard: the expected ack cycle and data for each port.
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t vexp[$];
  exp_t cexp[$];
  logic mon_en = 1'b0;

  always @(negedge clock) begin
    logic exp_v;
    logic exp_c;
    if (mon_en) begin
      exp_v = (vexp.size() > 0) && (vexp[0].cyc == cyc);
      exp_c = (cexp.size() > 0) && (cexp[0].cyc == cyc);
      check($sformatf("rand_vack_c%0d", cyc), 32'(vack), 32'(exp_v));
      check($sformatf("rand_cack_c%0d", cyc), 32'(cack), 32'(exp_c));
      if (exp_v) begin
        check($sformatf("rand_vq_c%0d", cyc), 32'(vq), 32'(vexp[0].data));
        void'(vexp.pop_front());
      end
      if (exp_c) begin
        check($sformatf("rand_cq_c%0d", cyc), 32'(cq), 32'(cexp[0].data));
        void'(cexp.pop_front());
      end
    end
  end

  logic [7:0] ref_mem [16];

  initial begin
    int v_free;
    int c_free;
    logic [3:0] a;
    logic [7:0] d;
    logic       w;

    // Row columns: vstb va cstb ca cd cw | ram_a ram_w ram_d vack vq cack cq
    // (ram_d is compared only in rows where ram_w is expected high).
    // Rows 0-6: CPU write, a write strobed in its ack cycle, a dropped strobe.
    vecs.push_back('{1'b0, 17'h000, 1'b1, 17'h100, 8'hA5, 1'b1, 17'h000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h100, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 17'h000, 1'b1, 17'h101, 8'h3C, 1'b1, 17'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b1, 17'h102, 8'hFF, 1'b1, 17'h101, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h101, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h101, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C});
    // Rows 7-9: CPU read of 0x100 returns A5 three cycles later.
    vecs.push_back('{1'b0, 17'h000, 1'b1, 17'h100, 8'h00, 1'b0, 17'h101, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C});
    // Rows 10-14: simultaneous video + CPU read; video wins, CPU one cycle later.
    vecs.push_back('{1'b1, 17'h101, 1'b1, 17'h055, 8'h00, 1'b0, 17'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h101, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 8'h0F});
    // Rows 15-20: CPU write then video read of the same address, next cycle.
    vecs.push_back('{1'b0, 17'h000, 1'b1, 17'h055, 8'h77, 1'b1, 17'h055, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h0F});
    vecs.push_back('{1'b1, 17'h055, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b1, 8'h77, 1'b0, 8'h3C, 1'b0, 8'h0F});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h0F});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 8'h77});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 8'h77});
    vecs.push_back('{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 17'h055, 1'b0, 8'h00, 1'b0, 8'h77, 1'b0, 8'h77});

    // Reset, with strobes held high to show they are ignored.
    reset = 1'b1;
    idle_inputs();
    vstb = 1'b1; va = 17'h0AB; cstb = 1'b1; ca = 17'h0CD; cw = 1'b1; cd = 8'hEE;
    repeat (3) step();
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    // Directed table.
    foreach (vecs[i]) begin
      step();
      vstb = vecs[i].vstb; va = vecs[i].va;
      cstb = vecs[i].cstb; ca = vecs[i].ca; cd = vecs[i].cd; cw = vecs[i].cw;
      @(negedge clock);
      check($sformatf("row%0d_ram_a", i), 32'(ram_a), 32'(vecs[i].e_a));
      check($sformatf("row%0d_ram_w", i), 32'(ram_w), 32'(vecs[i].e_w));
      if (vecs[i].e_w)
        check($sformatf("row%0d_ram_d", i), 32'(ram_d), 32'(vecs[i].e_d));
      check($sformatf("row%0d_vack", i), 32'(vack), 32'(vecs[i].e_vack));
      check($sformatf("row%0d_vq", i),   32'(vq),   32'(vecs[i].e_vq));
      check($sformatf("row%0d_cack", i), 32'(cack), 32'(vecs[i].e_cack));
      check($sformatf("row%0d_cq", i),   32'(cq),   32'(vecs[i].e_cq));
    end

    // Reset one cycle after a CPU read is issued: no ack, and all outputs clear.
    step(); idle_inputs();
    cstb = 1'b1; ca = 17'h300;
    step(); idle_inputs();
    reset = 1'b1; vstb = 1'b1; va = 17'h007;
    @(negedge clock);
    check("rst_read_issued_ram_a", 32'(ram_a), 32'h300);
    step(); idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("rst_after");
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      check($sformatf("rst_nocack_%0d", k), 32'(cack), 32'h0);
      check($sformatf("rst_novack_%0d", k), 32'(vack), 32'h0);
      check($sformatf("rst_ram_a_%0d", k),  32'(ram_a), 32'h0);
    end

    // A write already on ram_w at the reset edge still lands in RAM, unacked.
    step(); idle_inputs();
    cstb = 1'b1; ca = 17'h200; cd = 8'h99; cw = 1'b1;
    step(); idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    check("rstw_ram_w", 32'(ram_w), 32'h1);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rstw_nocack_%0d", k), 32'(cack), 32'h0);
      step();
    end
    cstb = 1'b1; ca = 17'h200; cw = 1'b0;
    step(); idle_inputs();
    step();
    step();
    @(negedge clock);
    check("rstw_read_cack", 32'(cack), 32'h1);
    check("rstw_read_cq",   32'(cq),   32'h99);

    // Alternating video/CPU strobes at random low addresses. With no
    // contention, each accepted strobe acks exactly three cycles later.
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    v_free = 0;
    c_free = 0;
    step(); idle_inputs();
    mon_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(); idle_inputs();
      a = 4'($urandom_range(0, 15));
      if (k % 2 == 0) begin
        vstb = 1'b1; va = AW'(a);
        if (cyc >= v_free) begin
          vexp.push_back('{cyc + 3, ref_mem[a]});
          v_free = cyc + 3;
        end
      end else begin
        d = 8'($urandom);
        w = 1'($urandom_range(0, 1));
        cstb = 1'b1; ca = AW'(a); cd = d; cw = w;
        if (cyc >= c_free) begin
          if (w) ref_mem[a] = d;
          cexp.push_back('{cyc + 3, w ? d : ref_mem[a]});
          c_free = cyc + 3;
        end
      end
    end
    step(); idle_inputs();
    repeat (6) step();
    @(negedge clock);
    mon_en = 1'b0;
    check("rand_vexp_drained", 32'(vexp.size()), 32'h0);
    check("rand_cexp_drained", 32'(cexp.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 17, SHALL set the byte-address width of every address port (2^AW bytes of single-port RAM).
REQ-002 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 vstb  in  1  SHALL be the video read strobe, one cycle wide.
REQ-005 va  in  AW  SHALL be the video address, sampled with vstb.
REQ-006 vack  out  1  SHALL be the video completion pulse, one cycle wide.
REQ-007 vq  out  8  SHALL be the video read data, valid while vack=1 and held until the next vack.
REQ-008 cstb  in  1  SHALL be the CPU access strobe, one cycle wide.
REQ-009 ca  in  AW  SHALL be the CPU address, sampled with cstb.
REQ-010 cd  in  8  SHALL be the CPU write data, sampled with cstb.
REQ-011 cw  in  1  SHALL select the CPU access type, sampled with cstb: 1=write, 0=read.
REQ-012 cack  out  1  SHALL be the CPU completion pulse, one cycle wide.
REQ-013 cq  out  8  SHALL be the CPU data, valid while cack=1 and held until the next cack.
REQ-014 ram_a  out  AW  SHALL be the registered RAM address.
REQ-015 ram_d  out  8  SHALL be the registered RAM write data.
REQ-016 ram_w  out  1  SHALL be the registered RAM write enable.
REQ-017 ram_q  in  8  SHALL be the RAM read data, valid one clock after ram_a/ram_w are presented.

Function
REQ-018 Each port SHALL hold at most one access, from strobe acceptance until its ack; a strobe on a busy port (pending or in flight) SHALL be ignored.
REQ-019 The arbiter SHALL latch an accepted strobe's address, data and type into that port's pending register.
REQ-020 At most one access SHALL be issued per cycle; candidates are pending accesses plus non-ignored strobes in the current cycle.
REQ-021 Video SHALL have fixed priority; a losing CPU candidate SHALL stay pending and SHALL be issued on the next cycle.
REQ-022 Issue SHALL mean loading ram_a, ram_d and ram_w at edge E; in cycles with no issue, ram_w SHALL be 0 and ram_a/ram_d SHALL hold.
REQ-023 Video issues SHALL always drive ram_w=0.
REQ-024 For an access issued at edge E, ram_q SHALL be captured into vq or cq at edge E+2, and the matching ack SHALL be high for the cycle after E+2.
REQ-025 An uncontended strobe sampled at edge S SHALL be acked after edge S+2; each lost arbitration SHALL add exactly one cycle.
REQ-026 A CPU write SHALL also ack, with cq equal to the written byte.
REQ-027 Throughput SHALL be one access per cycle; a 2-entry owner/valid pipeline SHALL route each ram_q to the correct port.
REQ-028 A port SHALL accept a new strobe in the same cycle its ack is high.
REQ-029 Video and CPU accesses to the same address issued on consecutive cycles SHALL be served in issue order; a read issued after a write SHALL see the new data.

Reset
REQ-030 While reset=1 at an edge, the block SHALL clear pending registers, pipeline valids, vack, cack, ram_w, ram_a, ram_d, vq and cq to 0.
REQ-031 Strobes in a cycle with reset=1 SHALL be ignored.
REQ-032 Accesses in flight at reset SHALL produce no ack; a write already on ram_w at the reset edge completes in RAM but is not acked.

Verification
REQ-033 Reset, then cstb with ca=0x00100, cd=0xA5, cw=1; a later cstb with ca=0x00100, cw=0 -> both ack 3 cycles after their strobe, and the read returns cq=0xA5.
REQ-034 vstb and cstb (read) in the same cycle -> ram_a shows the video address, then the CPU address on the next cycle; vack at +3 and cack at +4.
REQ-035 cstb asserted again while the CPU access is in flight -> the second strobe is ignored, exactly one cack occurs, and ram_w is never asserted for the dropped strobe.
REQ-036 Back-to-back alternating video/CPU strobes for 100 cycles at random addresses -> every strobe that is not ignored gets exactly one ack with data matching a reference memory model.
REQ-037 reset asserted one cycle after a CPU read issue -> no cack, and all outputs are 0 on the next cycle.
REQ-038 cstb (write) in the same cycle as the previous cack -> the write is accepted, with ram_w=1 one cycle later.
